clause_bank: RTL and testbench
==============================

Name: clause_bank

Overview:
- Parametrised successor to the single-port clause memory in the SAT datapath.
- Stores up to DEPTH clauses of LITS×LIT_W bits, each with a per-entry valid bit.
- Provides NUM_RD registered read ports with same-cycle write-through, an indexed write port, an append port (ready/valid) that allocates the lowest free slot, and a delete port.
- Feeds the propagation engine; the learnt-clause path appends through the append port.

Parameters:
DEPTH, 16, number of clause slots (power of two, ≥2)
LITS, 3, literals per clause
LIT_W, 11, bits per literal
NUM_RD, 2, independent read ports
(derived) CW = LITS*LIT_W (default 33); AW = $clog2(DEPTH); CNTW = $clog2(DEPTH+1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  indexed write strobe
wr_addr  in  AW  indexed write slot
wr_data  in  CW  indexed write clause
app_valid  in  1  append request
app_data  in  CW  clause to append
app_ready  out  1  append can be accepted this cycle
app_addr  out  AW  slot the append will take (meaningful when app_ready)
del_en  in  1  delete strobe
del_addr  in  AW  slot to invalidate
rd_addr  in  NUM_RD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  out  NUM_RD*CW  packed registered read data
rd_valid  out  NUM_RD  registered valid bit of the addressed slot
count  out  CNTW  number of valid slots
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (rst=1 at posedge): all valid bits cleared; count=0; rd_data=0; rd_valid=0. Array contents are not cleared. app_ready=0 while rst=1. Any requests in the reset cycle are dropped.
- app_ready = !rst && !full && !wr_en. Appends never share a cycle with an indexed write.
- app_addr: lowest-index slot whose valid bit is 0, computed combinationally from the current valid vector. Value is don't-care when full.
- Append fire (app_valid && app_ready): mem[app_addr] <= app_data; valid set; count+1.
- Indexed write: mem[wr_addr] <= wr_data; valid set. count+1 only if the slot was invalid, else unchanged (overwrite).
- Delete: valid[del_addr] cleared; count−1 only if the slot was valid. Deleting an invalid slot is a no-op.
- Delete and write/append to the same slot in one cycle: the write wins. Slot ends valid with new data; count reflects the net change.
- Delete of slot X and append to slot Y≠X in one cycle: both take effect; count unchanged.
- Reads, 1-cycle latency, registered, per port i:
  - If a write or append fires to rd_addr_i this cycle: rd_data_i ← new data, rd_valid_i ← 1 (write-through).
  - Else if a delete hits rd_addr_i this cycle: rd_data_i ← stored data, rd_valid_i ← 0.
  - Else: rd_data_i ← mem[rd_addr_i], rd_valid_i ← valid[rd_addr_i].
- Multiple ports may read the same slot; all receive identical data.
- count, full and empty are registered state, updated the same edge as the array.
- Addresses are always in range (DEPTH is a power of two), so no wrap logic is needed.

Decomposition:
- Package clause_pkg:
  - LIT_W, LITS, CW constants.
  - typedef lit_t (logic [LIT_W-1:0]).
  - typedef clause_t (lit_t [LITS-1:0]).
  - Helper function for slot index width.
- Sub-module free_slot_finder (param DEPTH): takes the valid vector; outputs the lowest free index and an any_free flag. Pure priority encoder, instantiated once.

Test Plan:
- Reset, then read slots 0 and 5 on ports 0/1 → rd_valid=2'b00, count=0, empty=1, app_ready=1, app_addr=0.
- Append 33'h1_2345_6789 with rd_addr0=0 in the same cycle → next cycle rd_data0=33'h1_2345_6789, rd_valid0=1; app_addr=1; count=1.
- Indexed write slot 5 = 33'h0_FF00_FF00 while port1 reads 5 and port0 reads 4 → port1 = new data/valid=1; port0 rd_valid=0; count=2. Rewrite slot 5 → count stays 2.
- Fill all 16 slots via append → full=1, app_ready=0; app_valid held high causes no change. Delete slot 3 → next cycle full=0, app_addr=3, count=15.
- Same cycle: delete slot 7, indexed write slot 7 = 33'h0_0000_00AA, port0 reads 7 → rd_valid0=1, data=33'h0_0000_00AA, count unchanged. Delete an already-invalid slot → count unchanged.
- Assert rst mid-stream with app_valid=1 → next cycle count=0, all rd_valid=0, rd_data=0, append not stored; after rst drops, app_addr=0.

Source files
------------

// File: rtl/clause_pkg.sv
// Shared clause geometry for the SAT clause bank: literal/clause types and index-width helper.
package clause_pkg;
  localparam int LIT_W = 11;
  localparam int LITS  = 3;
  localparam int CW    = LITS * LIT_W;

  typedef logic [LIT_W-1:0] lit_t;
  typedef lit_t [LITS-1:0]  clause_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/clause_bank_if.sv
// Request/response bundle for clause_bank: indexed write, append, delete, read ports and status.
interface clause_bank_if import clause_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2,
  parameter int CW_P   = CW
) ();
  localparam int AW   = idx_w(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [CW_P-1:0]        wr_data;
  logic                   app_valid;
  logic [CW_P-1:0]        app_data;
  logic                   app_ready;
  logic [AW-1:0]          app_addr;
  logic                   del_en;
  logic [AW-1:0]          del_addr;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*CW_P-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_valid;
  logic [CNTW-1:0]        count;
  logic                   full;
  logic                   empty;

  modport slave (
    input  wr_en, wr_addr, wr_data, app_valid, app_data, del_en, del_addr, rd_addr,
    output app_ready, app_addr, rd_data, rd_valid, count, full, empty
  );

  modport master (
    output wr_en, wr_addr, wr_data, app_valid, app_data, del_en, del_addr, rd_addr,
    input  app_ready, app_addr, rd_data, rd_valid, count, full, empty
  );
endinterface

// File: rtl/clause_bank_free_slot_finder.sv
// Priority encoder returning the lowest-index clear bit of the slot valid vector.
module free_slot_finder import clause_pkg::*; #(
  parameter  int DEPTH = 16,
  localparam int AW    = idx_w(DEPTH)
) (
  input  logic [DEPTH-1:0] valid_i,
  output logic [AW-1:0]    idx_o,
  output logic             any_free_o
);
  // Descending scan so the lowest free index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_i[i]) idx_o = AW'(i);
  end

  assign any_free_o = ~&valid_i;
endmodule

// File: rtl/clause_bank.sv
// Clause store with per-slot valid bits, multi-port registered reads, indexed write, append and delete.
module clause_bank import clause_pkg::*; #(
  parameter int DEPTH  = 16,
  parameter int LITS   = clause_pkg::LITS,
  parameter int LIT_W  = clause_pkg::LIT_W,
  parameter int NUM_RD = 2
) (
  input  logic         clk,
  input  logic         rst,
  clause_bank_if.slave bus
);
  localparam int CW   = LITS * LIT_W;
  localparam int AW   = idx_w(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [CW-1:0]                mem_q [DEPTH];
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [CNTW-1:0]              count_q, count_d;
  logic                         full_q, empty_q;
  logic [NUM_RD-1:0][CW-1:0]    rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]            rd_valid_q, rd_valid_d;
  logic [NUM_RD-1:0][AW-1:0]    rd_addr_w;

  logic [AW-1:0] free_idx;
  logic          any_free;
  logic          app_fire, do_w, inc, dec;
  logic [AW-1:0] w_addr;
  logic [CW-1:0] w_data;

  free_slot_finder #(.DEPTH(DEPTH)) u_free (
    .valid_i    (valid_q),
    .idx_o      (free_idx),
    .any_free_o (any_free)
  );

  assign rd_addr_w     = bus.rd_addr;
  assign bus.app_ready = !rst && any_free && !bus.wr_en;
  assign bus.app_addr  = free_idx;
  assign app_fire      = bus.app_valid && bus.app_ready;

  // Append is blocked by wr_en, so at most one of the two writers fires.
  assign do_w   = bus.wr_en || app_fire;
  assign w_addr = bus.wr_en ? bus.wr_addr : free_idx;
  assign w_data = bus.wr_en ? bus.wr_data : bus.app_data;

  // Write beats a same-slot delete; the count only moves on real valid transitions.
  assign inc = do_w && !valid_q[w_addr];
  assign dec = bus.del_en && valid_q[bus.del_addr] && !(do_w && (w_addr == bus.del_addr));
  assign count_d = count_q + CNTW'(inc) - CNTW'(dec);

  always_comb begin
    valid_d = valid_q;
    if (bus.del_en) valid_d[bus.del_addr] = 1'b0;
    if (do_w)       valid_d[w_addr]       = 1'b1;
  end

  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (do_w && (w_addr == rd_addr_w[p])) begin
        rd_data_d[p]  = w_data;
        rd_valid_d[p] = 1'b1;
      end else begin
        rd_data_d[p]  = mem_q[rd_addr_w[p]];
        rd_valid_d[p] = valid_q[rd_addr_w[p]] &&
                        !(bus.del_en && (bus.del_addr == rd_addr_w[p]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_w) mem_q[w_addr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      full_q     <= (count_d == CNTW'(DEPTH));
      empty_q    <= (count_d == '0);
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
endmodule

// File: tb/tb_clause_bank.sv
// Randomised bench for clause_bank against a slot-array model, plus directed literal checks.
module tb_clause_bank;
  localparam int DEPTH = 16, NUM_RD = 2, CW = 33, AW = 4, CNTW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clause_bank_if #(.DEPTH(DEPTH), .NUM_RD(NUM_RD), .CW_P(CW)) bus ();

  clause_bank #(.DEPTH(DEPTH), .LITS(3), .LIT_W(11), .NUM_RD(NUM_RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: slot contents, valid flags, whether contents are defined, expected read regs.
  logic [CW-1:0] mem_m [DEPTH];
  logic          val_m [DEPTH];
  logic          known_m [DEPTH];
  logic [CW-1:0] erd_d [NUM_RD];
  logic          erd_v [NUM_RD];
  logic          erd_k [NUM_RD];
  logic          seen_rst = 1'b0;

  logic [CW-1:0] nm [DEPTH];
  logic          nv [DEPTH];
  logic          nk [DEPTH];
  logic [CW-1:0] nrd_d [NUM_RD];
  logic          nrd_v [NUM_RD];
  logic          nrd_k [NUM_RD];
  int            exp_cnt, exp_free;

  initial for (int i = 0; i < DEPTH; i++) begin
    mem_m[i] = '0; val_m[i] = 1'b0; known_m[i] = 1'b0;
  end
  initial for (int p = 0; p < NUM_RD; p++) begin
    erd_d[p] = '0; erd_v[p] = 1'b0; erd_k[p] = 1'b1;
  end

  // A registered read shows the slot exactly as it stands after the edge.
  always_comb begin
    nm = mem_m; nv = val_m; nk = known_m;
    exp_cnt = 0; exp_free = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (val_m[i]) exp_cnt++;
      else if (exp_free < 0) exp_free = i;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      nrd_d[p] = '0; nrd_v[p] = 1'b0; nrd_k[p] = 1'b1;
    end
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) nv[i] = 1'b0;
    end else begin
      if (bus.del_en) nv[bus.del_addr] = 1'b0;
      if (bus.app_valid && !bus.wr_en && exp_cnt < DEPTH) begin
        nm[exp_free] = bus.app_data; nv[exp_free] = 1'b1; nk[exp_free] = 1'b1;
      end
      if (bus.wr_en) begin
        nm[bus.wr_addr] = bus.wr_data; nv[bus.wr_addr] = 1'b1; nk[bus.wr_addr] = 1'b1;
      end
      for (int p = 0; p < NUM_RD; p++) begin
        nrd_d[p] = nm[bus.rd_addr[p*AW +: AW]];
        nrd_v[p] = nv[bus.rd_addr[p*AW +: AW]];
        nrd_k[p] = nk[bus.rd_addr[p*AW +: AW]];
      end
    end
  end

  always @(posedge clk) begin
    mem_m    <= nm;
    val_m    <= nv;
    known_m  <= nk;
    erd_d    <= nrd_d;
    erd_v    <= nrd_v;
    erd_k    <= nrd_k;
    seen_rst <= seen_rst || rst;
  end

  always @(negedge clk) begin
    if (seen_rst) begin
      chk("count", 128'(bus.count), 128'(exp_cnt));
      chk("full",  128'(bus.full),  128'(exp_cnt == DEPTH));
      chk("empty", 128'(bus.empty), 128'(exp_cnt == 0));
      chk("app_ready", 128'(bus.app_ready), 128'(!rst && exp_cnt < DEPTH && !bus.wr_en));
      if (exp_cnt < DEPTH) chk("app_addr", 128'(bus.app_addr), 128'(exp_free));
      for (int p = 0; p < NUM_RD; p++) begin
        chk("rd_valid", 128'(bus.rd_valid[p]), 128'(erd_v[p]));
        if (erd_k[p]) chk("rd_data", 128'(bus.rd_data[p*CW +: CW]), 128'(erd_d[p]));
      end
    end
  end

  function automatic logic [CW-1:0] rnd_clause();
    return {1'($urandom_range(0, 1)), 32'($urandom)};
  endfunction

  task automatic clear_strobes();
    bus.wr_en = 1'b0; bus.app_valid = 1'b0; bus.del_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1 clear_strobes();
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_strobes();
    bus.wr_addr = '0; bus.wr_data = '0; bus.app_data = '0; bus.del_addr = '0;
    set_rd(0, 5);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("init rd_valid", 128'(bus.rd_valid), 128'(2'b00));
    chk("init count", 128'(bus.count), 128'(0));
    chk("init empty", 128'(bus.empty), 128'(1));
    chk("init app_ready", 128'(bus.app_ready), 128'(1));
    chk("init app_addr", 128'(bus.app_addr), 128'(0));

    bus.app_valid = 1'b1; bus.app_data = 33'h1_2345_6789; set_rd(0, 5);
    tick();
    chk("append rd_data0", 128'(bus.rd_data[CW-1:0]), 128'(33'h1_2345_6789));
    chk("append rd_valid0", 128'(bus.rd_valid[0]), 128'(1));
    chk("append app_addr", 128'(bus.app_addr), 128'(1));
    chk("append count", 128'(bus.count), 128'(1));

    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 33'h0_FF00_FF00; set_rd(4, 5);
    tick();
    chk("wr rd_data1", 128'(bus.rd_data[CW +: CW]), 128'(33'h0_FF00_FF00));
    chk("wr rd_valid", 128'(bus.rd_valid), 128'(2'b10));
    chk("wr count", 128'(bus.count), 128'(2));
    bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 33'h1_0000_0001;
    tick();
    chk("overwrite count", 128'(bus.count), 128'(2));

    for (int i = 0; i < 14; i++) begin
      bus.app_valid = 1'b1; bus.app_data = rnd_clause();
      tick();
    end
    chk("fill full", 128'(bus.full), 128'(1));
    chk("fill app_ready", 128'(bus.app_ready), 128'(0));
    for (int i = 0; i < 2; i++) begin
      bus.app_valid = 1'b1; bus.app_data = rnd_clause();
      tick();
    end
    chk("full hold count", 128'(bus.count), 128'(16));
    bus.del_en = 1'b1; bus.del_addr = 4'd3;
    tick();
    chk("del full", 128'(bus.full), 128'(0));
    chk("del app_addr", 128'(bus.app_addr), 128'(3));
    chk("del count", 128'(bus.count), 128'(15));

    bus.del_en = 1'b1; bus.del_addr = 4'd7;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 33'h0_0000_00AA; set_rd(7, 0);
    tick();
    chk("del+wr rd_valid0", 128'(bus.rd_valid[0]), 128'(1));
    chk("del+wr rd_data0", 128'(bus.rd_data[CW-1:0]), 128'(33'h0_0000_00AA));
    chk("del+wr count", 128'(bus.count), 128'(15));
    bus.del_en = 1'b1; bus.del_addr = 4'd3;
    tick();
    chk("del invalid count", 128'(bus.count), 128'(15));

    rst = 1'b1; bus.app_valid = 1'b1; bus.app_data = rnd_clause();
    tick();
    chk("rst count", 128'(bus.count), 128'(0));
    chk("rst rd_valid", 128'(bus.rd_valid), 128'(0));
    chk("rst rd_data", 128'(bus.rd_data), 128'(0));
    rst = 1'b0;
    tick();
    chk("post-rst app_addr", 128'(bus.app_addr), 128'(0));

    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.wr_en     = ($urandom_range(0, 4) == 0);
      bus.wr_addr   = AW'($urandom);
      bus.wr_data   = rnd_clause();
      bus.app_valid = ($urandom_range(0, 1) == 0);
      bus.app_data  = rnd_clause();
      bus.del_en    = ($urandom_range(0, 2) == 0);
      bus.del_addr  = ($urandom_range(0, 3) == 0) ? bus.wr_addr : AW'($urandom);
      set_rd(($urandom_range(0, 3) == 0) ? int'(bus.wr_addr) : int'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0) ? int'(bus.del_addr) : int'($urandom_range(0, 15)));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    clear_strobes();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
